pl_adc_burst_stream: RTL and testbench
======================================

// Module: pl_adc_burst_stream
// PURPOSE
//  Parametrised burst-capture front end for the CMOS parallel ADC, running in the ADC clock domain.
//  On a start request, delivers exactly i_Count decimated samples (live ADC data or a ramp test pattern).
//  Samples pass through a FIFO onto a valid/ready stream with TLAST, feeding the DMA/stream packer.
//  Done/clean handshake to the PS; a sticky overflow flag reports samples dropped under backpressure.
// PARAMETERS
//  DATA_W      12  ADC sample width; o_Tdata width
//  COUNT_W     32  width of i_Count and the internal delivered-sample counter
//  DECIM_W      8  width of i_Decim
//  FIFO_DEPTH  16  sample FIFO entries; power of 2, >= 4
// PORTS
//  i_CMOS_Clk    in   1                    ADC clock; all logic on its rising edge
//  i_Rst_n       in   1                    asynchronous active-low reset
//  i_CMOS_Data   in   DATA_W               ADC parallel data
//  i_Mode        in   1                    0 = ADC data, 1 = ramp test pattern; sampled at burst start
//  i_Decim       in   DECIM_W              keep 1 of every i_Decim+1 samples; sampled at burst start
//  i_Count       in   COUNT_W              samples to deliver per burst; sampled at burst start
//  i_ADC_Work    in   1                    start request (level), honoured only in IDLE
//  i_Done_Clean  in   1                    clears DONE state
//  o_Tdata       out  DATA_W               stream data
//  o_Tvalid      out  1                    stream valid
//  i_Tready      in   1                    stream ready
//  o_Tlast       out  1                    high on the i_Count-th beat only
//  o_ADC_Done    out  1                    burst fully accepted downstream; held until clean
//  o_Busy        out  1                    high in CAPTURE or DRAIN
//  o_Overflow    out  1                    sticky: a kept sample was dropped (FIFO full) this burst
//  o_Fifo_Level  out  $clog2(FIFO_DEPTH)+1 current FIFO occupancy
// BEHAVIOUR
//  Reset: every output 0; FIFO empty; state IDLE; counters, ramp and input register 0. Reset mid-burst aborts it.
//  Input stage: i_CMOS_Data is registered every cycle (r_in); the FIFO is written only from r_in.
//  FSM: IDLE -> CAPTURE when i_ADC_Work=1; latches i_Count, i_Mode, i_Decim; clears phase, ramp, delivered count, overflow.
//       IDLE -> DONE directly if latched count == 0 (no beats; o_ADC_Done high next cycle).
//       CAPTURE: phase counts 0..Decim, wrapping; on each phase==0 cycle a kept sample is produced:
//         value = r_in (mode 0) or ramp (mode 1); ramp += 1 on every kept sample, modulo 2^DATA_W.
//         FIFO not full -> push {value, last}, delivered += 1; last = (delivered+1 == count).
//         FIFO full -> sample dropped, o_Overflow <= 1, delivered unchanged (ramp still advances, gap visible).
//       CAPTURE -> DRAIN on the cycle the last-flagged sample is pushed.
//       DRAIN -> DONE on the edge that completes the handshake o_Tvalid & i_Tready & o_Tlast.
//       DONE: o_ADC_Done=1; i_ADC_Work ignored; i_Done_Clean=1 -> IDLE (a start is accepted from the next cycle).
//       i_Done_Clean outside DONE: no effect. Deasserting i_ADC_Work mid-burst: no effect.
//  Stream: o_Tdata/o_Tvalid/o_Tlast are registered FIFO head; a push into an empty FIFO is visible one cycle later.
//    A beat transfers on o_Tvalid & i_Tready; o_Tdata/o_Tlast are stable while o_Tvalid=1 and i_Tready=0.
//    Simultaneous push and pop when full: the push is refused (full is evaluated before the pop).
//    Full throughput: 1 beat/cycle with i_Tready held high.
//  o_Fifo_Level: updated every edge; equals push count minus pop count, range 0..FIFO_DEPTH.
//  Arithmetic: delivered counter COUNT_W bits, no wrap within a burst; ramp wraps 2^DATA_W-1 -> 0.
//  o_Overflow holds until the next burst start or reset; it is not cleared by i_Done_Clean.
// TESTING
//  T1 mode=1, decim=0, count=8, Tready=1: work pulse -> beats 0..7, Tlast on 7 only; Done after last beat; cleared by clean.
//  T2 mode=1, decim=0, count=40, depth 16, Tready=0 for 30 cycles, then 1:
//     Level saturates at 16; Overflow=1; ramp gap after value 15; exactly 40 beats with Tlast on the 40th.
//  T3 mode=0, decim=2, count=5, i_CMOS_Data=free-running cycle counter:
//     successive beats differ by exactly 3; 5 beats; Overflow=0.
//  T4 count=0: work -> no Tvalid ever; o_ADC_Done=1 and o_Busy=0 next cycle.
//  T5 reset low mid-burst (after 3 beats of count=10):
//     all outputs 0 immediately and Level=0; next burst (count=4, mode=1) delivers 0..3.
//  T6 in DONE, Done_Clean=1 and Work=1 same cycle -> IDLE; new burst starts the following cycle with Overflow cleared.

Source files
------------

// File: rtl/pl_adc_burst_stream_if.sv
// Valid/ready sample stream with TLAST between the ADC burst front end and the stream packer.
// Member names keep the front end's port naming so both sides read the same signals.
interface pl_adc_burst_stream_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] o_Tdata;
  logic              o_Tvalid;
  logic              i_Tready;
  logic              o_Tlast;

  modport master (output o_Tdata, output o_Tvalid, output o_Tlast, input i_Tready);
  modport slave  (input o_Tdata, input o_Tvalid, input o_Tlast, output i_Tready);
endinterface

// File: rtl/pl_adc_burst_stream.sv
// Burst-capture front end for the CMOS parallel ADC: decimates live data or a ramp into a
// small FIFO and delivers exactly i_Count beats on a valid/ready stream with TLAST.
module pl_adc_burst_stream #(
  parameter int DATA_W     = 12,
  parameter int COUNT_W    = 32,
  parameter int DECIM_W    = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_CMOS_Clk,
  input  logic                          i_Rst_n,
  input  logic [DATA_W-1:0]             i_CMOS_Data,
  input  logic                          i_Mode,
  input  logic [DECIM_W-1:0]            i_Decim,
  input  logic [COUNT_W-1:0]            i_Count,
  input  logic                          i_ADC_Work,
  input  logic                          i_Done_Clean,
  pl_adc_burst_stream_if.master         m_stream,
  output logic                          o_ADC_Done,
  output logic                          o_Busy,
  output logic                          o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                mode_q, mode_d;
  logic [DECIM_W-1:0]  decim_q, decim_d;
  logic [DECIM_W-1:0]  phase_q, phase_d;
  logic [DATA_W-1:0]   ramp_q, ramp_d;
  logic [COUNT_W-1:0]  delivered_q, delivered_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   r_in_q, r_in_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [DATA_W:0]     mem_q [FIFO_DEPTH];

  logic                full_s;
  logic                pop_s;
  logic                push_s;
  logic                push_last_s;
  logic [DATA_W-1:0]   push_data_s;
  logic [LVL_W-1:0]    remain_s;

  // Burst control: start latching, decimation phase, ramp, delivered count and overflow.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mode_d      = mode_q;
    decim_d     = decim_q;
    phase_d     = phase_q;
    ramp_d      = ramp_q;
    delivered_d = delivered_q;
    overflow_d  = overflow_q;
    r_in_d      = i_CMOS_Data;
    push_s      = 1'b0;
    push_last_s = 1'b0;
    push_data_s = mode_q ? ramp_q : r_in_q;
    // Full is judged on the current occupancy, so a same-cycle pop cannot make room.
    full_s      = (level_q == LVL_W'(FIFO_DEPTH));
    pop_s       = tvalid_q & m_stream.i_Tready;

    case (state_q)
      S_IDLE: begin
        if (i_ADC_Work) begin
          count_d     = i_Count;
          mode_d      = i_Mode;
          decim_d     = i_Decim;
          phase_d     = '0;
          ramp_d      = '0;
          delivered_d = '0;
          overflow_d  = 1'b0;
          if (i_Count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CAPTURE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (phase_q == decim_q) begin
          phase_d = '0;
        end else begin
          phase_d = phase_q + DECIM_W'(1);
        end
        if (phase_q == '0) begin
          ramp_d      = ramp_q + DATA_W'(1);
          push_last_s = ((delivered_q + COUNT_W'(1)) == count_q);
          if (!full_s) begin
            push_s      = 1'b1;
            delivered_d = delivered_q + COUNT_W'(1);
            if (push_last_s) begin
              state_d = S_DRAIN;
            end else begin
              state_d = S_CAPTURE;
            end
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          ramp_d = ramp_q;
        end
      end
      S_DRAIN: begin
        if (pop_s && tlast_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (i_Done_Clean) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_CAPTURE) || (state_d == S_DRAIN);
  end

  // FIFO pointers, occupancy and the registered head presented on the stream.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
    level_d  = level_q + LVL_W'(push_s) - LVL_W'(pop_s);
    remain_s = level_q - LVL_W'(pop_s);
    // With nothing left behind the popped head, a fresh push becomes the head directly.
    if (remain_s == '0) begin
      tvalid_d = push_s;
      tdata_d  = push_s ? push_data_s : '0;
      tlast_d  = push_s & push_last_s;
    end else begin
      tvalid_d = 1'b1;
      tdata_d  = mem_q[rd_ptr_d][DATA_W-1:0];
      tlast_d  = mem_q[rd_ptr_d][DATA_W];
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      mode_q      <= 1'b0;
      decim_q     <= '0;
      phase_q     <= '0;
      ramp_q      <= '0;
      delivered_q <= '0;
      overflow_q  <= 1'b0;
      r_in_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      decim_q     <= decim_d;
      phase_q     <= phase_d;
      ramp_q      <= ramp_d;
      delivered_q <= delivered_d;
      overflow_q  <= overflow_d;
      r_in_q      <= r_in_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Sample storage; contents are only meaningful between the pointers.
  always_ff @(posedge i_CMOS_Clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {push_last_s, push_data_s};
    end
  end

  assign m_stream.o_Tdata  = tdata_q;
  assign m_stream.o_Tvalid = tvalid_q;
  assign m_stream.o_Tlast  = tlast_q;
  assign o_ADC_Done        = done_q;
  assign o_Busy            = busy_q;
  assign o_Overflow        = overflow_q;
  assign o_Fifo_Level      = level_q;

endmodule

// File: tb/tb_pl_adc_burst_stream.sv
// Self-checking bench for pl_adc_burst_stream: vector table, corner-case sequences and
// randomized bursts judged by burst-level rules (beat count, TLAST, sample spacing, overflow).
module tb_pl_adc_burst_stream;

  localparam int DATA_W     = 12;
  localparam int COUNT_W    = 32;
  localparam int DECIM_W    = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DATA_W-1:0]   cmos_data = '0;
  logic                mode = 1'b0;
  logic [DECIM_W-1:0]  decim = '0;
  logic [COUNT_W-1:0]  count = '0;
  logic                work = 1'b0;
  logic                clean = 1'b0;
  logic                done, busy, ovf;
  logic [LVL_W-1:0]    level;

  pl_adc_burst_stream_if #(.DATA_W(DATA_W)) m_if ();

  pl_adc_burst_stream #(
    .DATA_W(DATA_W), .COUNT_W(COUNT_W), .DECIM_W(DECIM_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_CMOS_Clk   (clk),
    .i_Rst_n      (rst_n),
    .i_CMOS_Data  (cmos_data),
    .i_Mode       (mode),
    .i_Decim      (decim),
    .i_Count      (count),
    .i_ADC_Work   (work),
    .i_Done_Clean (clean),
    .m_stream     (m_if),
    .o_ADC_Done   (done),
    .o_Busy       (busy),
    .o_Overflow   (ovf),
    .o_Fifo_Level (level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    bit mode;
    int decim;
    int count;
    int hold;
    bit exp_ovf;
    int exp_step;
    bit exp_tput;
    int exp_gap;
    int exp_maxlvl;
  } vec_t;

  beat_t beats[$];
  int    beat_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc_g  = 0;

  // Free-running ADC data: a cycle counter, so decimated samples expose their spacing.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cmos_data = cmos_data + 1'b1;
      cyc_g = cyc_g + 1;
    end
  end

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void check_idle(string tag);
    chk({tag, " tdata"}, longint'(m_if.o_Tdata), 0);
    chk({tag, " tvalid"}, longint'(m_if.o_Tvalid), 0);
    chk({tag, " tlast"}, longint'(m_if.o_Tlast), 0);
    chk({tag, " done"}, longint'(done), 0);
    chk({tag, " busy"}, longint'(busy), 0);
    chk({tag, " overflow"}, longint'(ovf), 0);
    chk({tag, " level"}, longint'(level), 0);
  endfunction

  // Rules: count beats, one TLAST on the final beat, ramp starts at 0, successive samples
  // are `step` apart unless samples were dropped (then a multiple), overflow iff a gap.
  function automatic int check_beats(string tag, bit m, int c, int step, bit ovf_dut);
    int nlast = 0;
    int first_gap = -1;
    int bad = 0;
    logic [DATA_W-1:0] dlt;
    chk({tag, " beat count"}, beats.size(), c);
    foreach (beats[i]) if (beats[i].last) nlast++;
    chk({tag, " tlast count"}, nlast, 1);
    if (beats.size() > 0) begin
      chk({tag, " tlast on final beat"}, longint'(beats[beats.size()-1].last), 1);
      if (m) chk({tag, " ramp first value"}, longint'(beats[0].data), 0);
    end
    for (int i = 1; i < beats.size(); i++) begin
      dlt = beats[i].data - beats[i-1].data;
      if (int'(dlt) != step) begin
        if (first_gap < 0) first_gap = i;
        if (dlt == '0 || (int'(dlt) % step) != 0) bad++;
      end
    end
    chk({tag, " sample spacing violations"}, bad, 0);
    chk({tag, " overflow matches gap"}, longint'(ovf_dut), longint'(first_gap >= 0));
    return first_gap;
  endfunction

  task automatic run_burst(input bit do_start, input bit m, input int d, input int c,
                           input int hold, input bit rnd, output bit ovf_o, output int max_lvl);
    bit    stall = 1'b0;
    beat_t prev = '0;
    int    unstable = 0;
    int    budget = 200 + 8 * c * (d + 1);
    int    n = 0;
    beats.delete();
    beat_cyc.delete();
    max_lvl = 0;
    if (do_start) begin
      mode  = m;
      decim = DECIM_W'(d);
      count = COUNT_W'(c);
      work  = 1'b1;
      m_if.i_Tready = 1'b0;
      @(posedge clk);
      #1;
      work = 1'b0;
    end
    while (!done && n < budget) begin
      m_if.i_Tready = (n >= hold) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      @(negedge clk);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (stall && (!m_if.o_Tvalid || prev != {m_if.o_Tdata, m_if.o_Tlast})) unstable++;
      if (m_if.o_Tvalid && m_if.i_Tready) begin
        beats.push_back({m_if.o_Tdata, m_if.o_Tlast});
        beat_cyc.push_back(cyc_g);
      end
      stall = m_if.o_Tvalid && !m_if.i_Tready;
      prev  = {m_if.o_Tdata, m_if.o_Tlast};
      @(posedge clk);
      #1;
      n++;
    end
    chk("burst completes within budget", longint'(done), 1);
    chk("stream stable under backpressure", unstable, 0);
    ovf_o = ovf;
  endtask

  task automatic finish_burst(string tag);
    chk({tag, " done after burst"}, longint'(done), 1);
    chk({tag, " busy after burst"}, longint'(busy), 0);
    chk({tag, " level after burst"}, longint'(level), 0);
    chk({tag, " tvalid after burst"}, longint'(m_if.o_Tvalid), 0);
    clean = 1'b1;
    @(posedge clk);
    #1;
    clean = 1'b0;
    chk({tag, " done cleared by clean"}, longint'(done), 0);
  endtask

  vec_t vecs[7];

  initial begin
    bit o;
    int ml;
    int g;
    int n;
    int k;
    bit seen;

    vecs[0] = '{1'b1, 0, 8,    0,  1'b0, 1, 1'b1, -1, 1};
    vecs[1] = '{1'b1, 0, 40,   30, 1'b1, 1, 1'b0, 16, 16};
    vecs[2] = '{1'b0, 2, 5,    0,  1'b0, 3, 1'b0, -1, 1};
    vecs[3] = '{1'b1, 3, 6,    0,  1'b0, 1, 1'b0, -1, 1};
    vecs[4] = '{1'b0, 0, 20,   0,  1'b0, 1, 1'b1, -1, 1};
    vecs[5] = '{1'b1, 0, 1,    0,  1'b0, 1, 1'b1, -1, 1};
    vecs[6] = '{1'b1, 0, 4098, 0,  1'b0, 1, 1'b1, -1, 1};

    m_if.i_Tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset asserted");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("after reset");

    foreach (vecs[v]) begin
      run_burst(1'b1, vecs[v].mode, vecs[v].decim, vecs[v].count, vecs[v].hold, 1'b0, o, ml);
      g = check_beats("VEC", vecs[v].mode, vecs[v].count, vecs[v].exp_step, o);
      chk("VEC overflow", longint'(o), longint'(vecs[v].exp_ovf));
      chk("VEC first gap index", g, vecs[v].exp_gap);
      chk("VEC max level", ml, vecs[v].exp_maxlvl);
      if (vecs[v].exp_tput && beats.size() > 0)
        chk("VEC back-to-back beats", beat_cyc[beat_cyc.size()-1] - beat_cyc[0], vecs[v].count - 1);
      finish_burst("VEC");
    end

    // Zero-length burst goes straight to DONE with no beats.
    mode = 1'b1; decim = '0; count = '0; work = 1'b1; m_if.i_Tready = 1'b1;
    @(posedge clk);
    #1;
    work = 1'b0;
    chk("ZERO done next cycle", longint'(done), 1);
    chk("ZERO busy", longint'(busy), 0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (m_if.o_Tvalid) seen = 1'b1;
    end
    chk("ZERO no tvalid", longint'(seen), 0);
    @(posedge clk);
    #1;
    finish_burst("ZERO");

    // Reset in the middle of a burst, then a clean short burst.
    mode = 1'b1; decim = '0; count = 10; work = 1'b1; m_if.i_Tready = 1'b1;
    @(posedge clk);
    #1;
    work = 1'b0;
    n = 0;
    k = 0;
    while (n < 3 && k < 100) begin
      @(negedge clk);
      if (m_if.o_Tvalid && m_if.i_Tready) n++;
      @(posedge clk);
      #1;
      k++;
    end
    chk("RST beats before reset", n, 3);
    chk("RST busy before reset", longint'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("RST mid-burst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(1'b1, 1'b1, 0, 4, 0, 1'b0, o, ml);
    g = check_beats("RST next burst", 1'b1, 4, 1, o);
    chk("RST next burst gap", g, -1);
    finish_burst("RST");

    // Clean and start together in DONE: clean wins, the start lands one cycle later.
    run_burst(1'b1, 1'b1, 0, 20, 30, 1'b0, o, ml);
    chk("CLS overflow set", longint'(o), 1);
    mode = 1'b1; decim = '0; count = 5; clean = 1'b1; work = 1'b1; m_if.i_Tready = 1'b1;
    @(posedge clk);
    #1;
    clean = 1'b0;
    chk("CLS done cleared", longint'(done), 0);
    chk("CLS idle not busy", longint'(busy), 0);
    chk("CLS overflow kept by clean", longint'(ovf), 1);
    @(posedge clk);
    #1;
    work = 1'b0;
    chk("CLS busy next cycle", longint'(busy), 1);
    chk("CLS overflow cleared by start", longint'(ovf), 0);
    run_burst(1'b0, 1'b1, 0, 5, 0, 1'b0, o, ml);
    g = check_beats("CLS burst", 1'b1, 5, 1, o);
    chk("CLS burst gap", g, -1);
    finish_burst("CLS");

    // Randomized bursts under random backpressure.
    for (int r = 0; r < 12; r++) begin
      bit rm;
      int rd;
      int rc;
      int rh;
      rm = 1'($urandom_range(0, 1));
      rd = int'($urandom_range(0, 3));
      rc = int'($urandom_range(1, 40));
      rh = int'($urandom_range(0, 25));
      run_burst(1'b1, rm, rd, rc, rh, 1'b1, o, ml);
      g = check_beats("RND", rm, rc, rm ? 1 : rd + 1, o);
      chk("RND level bound", longint'(ml <= FIFO_DEPTH), 1);
      finish_burst("RND");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
